beam_scan_ctrl: RTL

Time-multiplexed scheduler for a bank of IR break-beam sensors that share one optical space. Only one emitter is lit at a time, which prevents crosstalk. The block lets each receiver settle, samples it, debounces per channel, and counts beam-break objects per channel. It sits between the GPIO sense/emitter pins and the LED/display logic, and issues break events over a valid/ready handshake.

---
 rtl/beam_scan_ctrl_if.sv | 13 +
 rtl/beam_scan_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/beam_scan_ctrl_if.sv
// Break-event valid/ready channel from beam_scan_ctrl to its consumer.
interface beam_scan_ctrl_if #(
    parameter int unsigned NUM_CH = 4
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic            evt_valid;
    logic [CH_W-1:0] evt_ch;
    logic            evt_ready;

    modport master (output evt_valid, output evt_ch, input evt_ready);
    modport slave  (input evt_valid, input evt_ch, output evt_ready);
endinterface

// File: rtl/beam_scan_ctrl.sv
// beam_scan_ctrl: time-multiplexed IR break-beam scanner with per-channel
// debounce, saturating object counters and a valid/ready break-event output.
// Optional stuck-beam detection is compiled in when BEAM_FAULT_EN is defined.
module beam_scan_ctrl #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned SETTLE_CYCLES = 500,
    parameter int unsigned GAP_CYCLES    = 100,
    parameter int unsigned DEB_SAMPLES   = 3,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned FAULT_SCANS   = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [NUM_CH-1:0]          sense,
    output logic [NUM_CH-1:0]          emit_en,
    output logic [NUM_CH-1:0]          beam_state,
    beam_scan_ctrl_if.master           evt,
    input  logic [$clog2(NUM_CH)-1:0]  cnt_sel,
    output logic [CNT_W-1:0]           cnt_out,
    input  logic                       clr_counts,
    output logic                       ovf,
    output logic                       scan_done,
    output logic [NUM_CH-1:0]          fault
);
    localparam int unsigned CH_W    = $clog2(NUM_CH);
    localparam int unsigned TMR_MAX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned DEB_W   = $clog2(DEB_SAMPLES + 1);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, EMIT, SAMPLE, GAP} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [NUM_CH-1:0] emit_d;
    logic              scan_done_d;
    logic [NUM_CH-1:0] sync1_q, sync2_q;
    logic [DEB_W-1:0]  deb_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic              sample_c, brk_c, flip_c, rise_c, load_c;

    // Scan sequencer: next state, channel, phase timer and registered outputs.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        tmr_d       = tmr_q;
        scan_done_d = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            ch_d    = '0;
            tmr_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = EMIT;
                    ch_d    = '0;
                    tmr_d   = '0;
                end
                EMIT: begin
                    if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                        state_d = SAMPLE;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                SAMPLE: begin
                    state_d = GAP;
                    tmr_d   = '0;
                end
                GAP: begin
                    if (tmr_q == TMR_W'(GAP_CYCLES - 1)) begin
                        state_d = EMIT;
                        tmr_d   = '0;
                        if (ch_q == LAST_CH) begin
                            ch_d        = '0;
                            scan_done_d = 1'b1;
                        end else begin
                            ch_d = ch_q + CH_W'(1);
                        end
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        emit_d = (state_d == EMIT || state_d == SAMPLE) ? (NUM_CH'(1) << ch_d) : '0;
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            tmr_q     <= '0;
            emit_en   <= '0;
            scan_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            tmr_q     <= tmr_d;
            emit_en   <= emit_d;
            scan_done <= scan_done_d;
        end
    end

    // Two-flop synchroniser for the asynchronous receiver inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sense;
            sync2_q <= sync1_q;
        end
    end

    // Sample decode: debounce threshold hit, break edge and event acceptance.
    always_comb begin
        sample_c = (state_q == SAMPLE) && enable;
        brk_c    = ~sync2_q[ch_q];
        flip_c   = sample_c && (brk_c != beam_state[ch_q])
                   && ((32'(deb_q[ch_q]) + 32'd1) >= DEB_SAMPLES);
        rise_c   = flip_c && brk_c;
        load_c   = rise_c && (!evt.evt_valid || evt.evt_ready);
    end

    // Per-channel debounce of the sampled beam state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beam_state <= '0;
            for (int i = 0; i < NUM_CH; i++) deb_q[i] <= '0;
        end else if (!enable) begin
            for (int i = 0; i < NUM_CH; i++) deb_q[i] <= '0;
        end else if (sample_c) begin
            if (flip_c) begin
                beam_state[ch_q] <= brk_c;
                deb_q[ch_q]      <= '0;
            end else if (brk_c != beam_state[ch_q]) begin
                deb_q[ch_q] <= deb_q[ch_q] + DEB_W'(1);
            end else begin
                deb_q[ch_q] <= '0;
            end
        end
    end

    // Saturating object counters and sticky overflow; clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_counts) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            ovf <= 1'b0;
        end else begin
            if (rise_c && cnt_q[ch_q] != CNT_MAX) cnt_q[ch_q] <= cnt_q[ch_q] + CNT_W'(1);
            if (rise_c && !load_c) ovf <= 1'b1;
        end
    end

    // Break-event holding register; stable until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt.evt_valid <= 1'b0;
            evt.evt_ch    <= '0;
        end else if (load_c) begin
            evt.evt_valid <= 1'b1;
            evt.evt_ch    <= ch_q;
        end else if (evt.evt_valid && evt.evt_ready) begin
            evt.evt_valid <= 1'b0;
        end
    end

    assign cnt_out = (32'(cnt_sel) < NUM_CH) ? cnt_q[cnt_sel] : '0;

`ifdef BEAM_FAULT_EN
    localparam int unsigned FS_W = $clog2(FAULT_SCANS + 1);
    logic [FS_W-1:0] fscan_q [NUM_CH];

    // Stuck-beam detection: count whole scans spent broken, flag at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_counts) begin
            for (int i = 0; i < NUM_CH; i++) fscan_q[i] <= '0;
            fault <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!beam_state[i]) begin
                    fscan_q[i] <= '0;
                end else if (scan_done && 32'(fscan_q[i]) < FAULT_SCANS) begin
                    fscan_q[i] <= fscan_q[i] + FS_W'(1);
                    if (32'(fscan_q[i]) + 32'd1 == FAULT_SCANS) fault[i] <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_fault_cfg;
    assign unused_fault_cfg = ^32'(FAULT_SCANS);
    assign fault = '0;
`endif

endmodule
